// File: rtl/axi4_mem_tester_if.sv
// axi4_if: AXI4 bus bundle (AW, W, B, AR, R) with master and slave views.
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi4_mem_tester.sv
// axi4_mem_tester: AXI4 initiator that writes seed+word over a region as INCR bursts,
// reads the region back, and reports pass/fail, an error count and the first failing address.
module axi4_mem_tester #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int BURST_LEN          = 4,
  parameter int NUM_BURSTS         = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] base_addr_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    seed_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [15:0]                   err_count_o,
  output logic [AXI4_ADDRESS_WIDTH-1:0] first_err_addr_o,
  axi4_if.master                        m
);
  localparam int AW        = AXI4_ADDRESS_WIDTH;
  localparam int DW        = AXI4_DATA_WIDTH;
  localparam int SIZE_LOG2 = $clog2(DW / 8);
  localparam int BEAT_W    = $clog2(BURST_LEN + 1);
  localparam int BURST_W   = $clog2(NUM_BURSTS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [AW-1:0]        r_base;
  logic [DW-1:0]        r_seed;
  logic [DW-1:0]        r_word;        // linear word index across the whole region
  logic [BEAT_W-1:0]    r_beat;        // beat index inside the current burst
  logic [BURST_W-1:0]   r_burst;
  logic [AW-1:0]        r_burst_addr;  // AWADDR of the burst awaiting its B response
  logic [15:0]          r_err_count;
  logic [AW-1:0]        r_first_err_addr;
  logic                 r_result_valid;

  logic [AW-1:0]        w_word_addr;
  logic [DW-1:0]        w_exp_data;
  logic                 w_last_beat;
  logic                 w_last_burst;
  logic [1:0]           w_err_inc;
  logic [AW-1:0]        w_err_addr;
  logic [16:0]          w_err_sum;
  logic [15:0]          w_err_next;
  logic                 w_unused_ids;

  // The word index sits at burst*BURST_LEN whenever an AW/AR is issued, so one adder serves
  // both the burst address and the per-beat error address.
  assign w_word_addr  = r_base + (AW'(r_word) << SIZE_LOG2);
  assign w_exp_data   = r_seed + r_word;
  assign w_last_beat  = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_last_burst = (r_burst == BURST_W'(NUM_BURSTS - 1));
  assign w_err_sum    = {1'b0, r_err_count} + 17'(w_err_inc);
  assign w_err_next   = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  assign w_unused_ids = ^{m.bid, m.rid};

  // Request fields are pure functions of registered state: stable while stalled, never READY-dependent.
  assign m.awid    = {AXI4_ID_WIDTH{1'b0}};
  assign m.awaddr  = w_word_addr;
  assign m.awlen   = 8'(BURST_LEN - 1);
  assign m.awsize  = 3'(SIZE_LOG2);
  assign m.awburst = 2'b01;
  assign m.wdata   = w_exp_data;
  assign m.wstrb   = '1;
  assign m.wlast   = w_last_beat;
  assign m.arid    = {AXI4_ID_WIDTH{1'b0}};
  assign m.araddr  = w_word_addr;
  assign m.arlen   = 8'(BURST_LEN - 1);
  assign m.arsize  = 3'(SIZE_LOG2);
  assign m.arburst = 2'b01;

  assign done_o           = (r_state == S_DONE);
  assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign pass_o           = (done_o || r_result_valid) && (r_err_count == 16'd0);
  assign err_count_o      = r_err_count;
  assign first_err_addr_o = r_first_err_addr;

  // Next-state and channel handshake outputs of the pass sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    m.awvalid    = 1'b0;
    m.wvalid     = 1'b0;
    m.bready     = 1'b0;
    m.arvalid    = 1'b0;
    m.rready     = 1'b0;
    case (r_state)
      S_IDLE: if (start_i) w_next_state = S_AW;
      S_AW: begin
        m.awvalid = 1'b1;
        if (m.awready) w_next_state = S_W;
      end
      S_W: begin
        m.wvalid = 1'b1;
        if (m.wready && w_last_beat) w_next_state = S_B;
      end
      S_B: begin
        m.bready = 1'b1;
        if (m.bvalid) w_next_state = w_last_burst ? S_AR : S_AW;
      end
      S_AR: begin
        m.arvalid = 1'b1;
        if (m.arready) w_next_state = S_R;
      end
      S_R: begin
        m.rready = 1'b1;
        if (m.rvalid && w_last_beat) w_next_state = w_last_burst ? S_DONE : S_AR;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-cycle error detection: one count per failing check, one address per beat.
  always_comb begin
    w_err_inc  = 2'd0;
    w_err_addr = w_word_addr;
    if (r_state == S_B && m.bvalid && m.bresp != 2'b00) begin
      w_err_inc  = 2'd1;
      w_err_addr = r_burst_addr;
    end else if (r_state == S_R && m.rvalid) begin
      w_err_inc = 2'(m.rdata != w_exp_data) + 2'(m.rresp != 2'b00) + 2'(m.rlast != w_last_beat);
    end
  end

  // State register, pass counters and error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_seed           <= '0;
      r_word           <= '0;
      r_beat           <= '0;
      r_burst          <= '0;
      r_burst_addr     <= '0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_result_valid   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_base           <= base_addr_i;
          r_seed           <= seed_i;
          r_word           <= '0;
          r_beat           <= '0;
          r_burst          <= '0;
          r_err_count      <= '0;
          r_first_err_addr <= '0;
          r_result_valid   <= 1'b0;
        end
        S_AW: if (m.awready) r_burst_addr <= w_word_addr;
        S_W: if (m.wready) begin
          r_word <= r_word + 1'b1;
          r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
        S_B: if (m.bvalid) begin
          if (w_last_burst) begin
            r_burst <= '0;
            r_word  <= '0;
          end else begin
            r_burst <= r_burst + 1'b1;
          end
        end
        S_R: if (m.rvalid) begin
          r_word <= r_word + 1'b1;
          r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
          if (w_last_beat && !w_last_burst) r_burst <= r_burst + 1'b1;
        end
        S_DONE:  r_result_valid <= 1'b1;
        default: ;
      endcase
      if (w_err_inc != 2'd0) begin
        r_err_count <= w_err_next;
        if (r_err_count == 16'd0) r_first_err_addr <= w_err_addr;
      end
    end
  end
endmodule

// File: tb/tb_axi4_mem_tester.sv
// tb_axi4_mem_tester: directed bench with a one-outstanding AXI4 slave model and fault knobs.
module tb_axi4_mem_tester;
  localparam int AW = 32, DW = 32, IW = 4, BL = 4, NB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err;

  always #5 clk = ~clk;

  axi4_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  axi4_mem_tester #(
    .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
    .BURST_LEN(BL), .NUM_BURSTS(NB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr), .seed_i(seed),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .first_err_addr_o(first_err), .m(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fault knobs and slave bookkeeping.
  int            flip_word = -1;
  int            bresp_err_burst = -1;
  bit            early_rlast = 1'b0;
  bit            stall_en = 1'b0;
  logic [AW-1:0] cur_base = '0;

  logic [DW-1:0] mem [0:1023];
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0]    s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;
  logic [9:0]    s_waddr, s_raddr;
  int            s_wcnt, s_rcnt, s_rword;
  logic          s_bpend, s_rpend;
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, proto_err, stab_err;
  logic          p_aw_stall, p_ar_stall, p_w_stall, p_wlast;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;

  assign bus.awready = s_awready;
  assign bus.wready  = s_wready;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.bid     = '0;
  assign bus.arready = s_arready;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;
  assign bus.rlast   = s_rlast;
  assign bus.rid     = '0;

  // Slave model: one transaction at a time, optional random stalls, injected faults.
  always @(posedge clk) begin
    if (rst) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_arready <= 1'b0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rlast <= 1'b0;
      s_rresp <= 2'b00; s_rdata <= '0; s_waddr <= '0; s_raddr <= '0;
      s_wcnt <= 0; s_rcnt <= 0; s_rword <= 0; s_bpend <= 1'b0; s_rpend <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      proto_err <= 0; stab_err <= 0;
      p_aw_stall <= 1'b0; p_ar_stall <= 1'b0; p_w_stall <= 1'b0;
      p_awaddr <= '0; p_araddr <= '0; p_wdata <= '0; p_wlast <= 1'b0;
    end else begin
      s_awready <= !stall_en || ($urandom_range(0, 1) == 1);
      s_wready  <= !stall_en || ($urandom_range(0, 1) == 1);
      s_arready <= !stall_en || ($urandom_range(0, 1) == 1);

      if (bus.awvalid && s_awready) begin
        s_waddr <= bus.awaddr[11:2];
        s_wcnt  <= 0;
        aw_cnt  <= aw_cnt + 1;
        if (bus.awaddr != cur_base + AW'(aw_cnt * BL * 4) || bus.awlen != 8'(BL - 1) ||
            bus.awsize != 3'd2 || bus.awburst != 2'b01 || bus.awid != '0)
          proto_err <= proto_err + 1;
      end
      if (bus.wvalid && s_wready) begin
        mem[10'(s_waddr + 10'(s_wcnt))] <= bus.wdata;
        s_wcnt <= s_wcnt + 1;
        w_cnt  <= w_cnt + 1;
        if (bus.wlast != (s_wcnt == BL - 1) || bus.wstrb != '1) proto_err <= proto_err + 1;
        if (s_wcnt == BL - 1) s_bpend <= 1'b1;
      end
      if (s_bvalid && bus.bready) begin
        s_bvalid <= 1'b0;
        b_cnt    <= b_cnt + 1;
      end else if (s_bpend && !s_bvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (b_cnt == bresp_err_burst) ? 2'b10 : 2'b00;
        s_bpend  <= 1'b0;
      end

      if (bus.arvalid && s_arready) begin
        s_raddr <= bus.araddr[11:2];
        s_rword <= int'((bus.araddr - cur_base) >> 2);
        s_rpend <= 1'b1;
        s_rcnt  <= 0;
        ar_cnt  <= ar_cnt + 1;
        if (bus.araddr != cur_base + AW'(ar_cnt * BL * 4) || bus.arlen != 8'(BL - 1) ||
            bus.arsize != 3'd2 || bus.arburst != 2'b01 || bus.arid != '0)
          proto_err <= proto_err + 1;
      end
      if (s_rvalid && bus.rready) begin
        s_rvalid <= 1'b0;
        r_cnt    <= r_cnt + 1;
        s_rcnt   <= s_rcnt + 1;
        if (s_rcnt == BL - 1) s_rpend <= 1'b0;
      end else if (s_rpend && !s_rvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[10'(s_raddr + 10'(s_rcnt))] ^ DW'((s_rword + s_rcnt == flip_word) ? 1 : 0);
        s_rresp  <= 2'b00;
        s_rlast  <= (early_rlast && ar_cnt == 1) ? (s_rcnt == 2) : (s_rcnt == BL - 1);
      end

      // Stalled requests must keep VALID and payload unchanged on the next cycle.
      if (p_aw_stall && (!bus.awvalid || bus.awaddr != p_awaddr)) stab_err <= stab_err + 1;
      if (p_ar_stall && (!bus.arvalid || bus.araddr != p_araddr)) stab_err <= stab_err + 1;
      if (p_w_stall && (!bus.wvalid || bus.wdata != p_wdata || bus.wlast != p_wlast))
        stab_err <= stab_err + 1;
      p_aw_stall <= bus.awvalid && !s_awready;
      p_ar_stall <= bus.arvalid && !s_arready;
      p_w_stall  <= bus.wvalid && !s_wready;
      p_awaddr   <= bus.awaddr;
      p_araddr   <= bus.araddr;
      p_wdata    <= bus.wdata;
      p_wlast    <= bus.wlast;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a pass and waits (bounded) for done_o; optionally pokes start_i mid-pass.
  task automatic run_pass(input logic [AW-1:0] b, input logic [DW-1:0] s, input bit poke,
                          output int dones, output bit timed_out, output logic busy_seen);
    cur_base  = b;
    base_addr = b;
    seed      = s;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    busy_seen = busy;
    dones     = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (poke && i == 20) begin
        start = 1'b1; base_addr = 32'h40; seed = 32'hDEAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        dones++;
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  int   dones;
  bit   tmo;
  logic bsy;
  bit   saw_w;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err, 0);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    rst = 1'b0;

    // Clean pass, with a start_i pulse mid-pass that must be ignored.
    run_pass(32'h0, 32'h1000, 1'b1, dones, tmo, bsy);
    check("clean_timeout", tmo, 0);
    check("clean_busy_after_start", bsy, 1);
    check("clean_done_pulses", dones, 1);
    check("clean_pass", pass, 1);
    check("clean_err", err_count, 0);
    check("clean_busy_idle", busy, 0);
    check("clean_aw", aw_cnt, 16);
    check("clean_w", w_cnt, 64);
    check("clean_b", b_cnt, 16);
    check("clean_ar", ar_cnt, 16);
    check("clean_r", r_cnt, 64);
    check("clean_proto", proto_err, 0);
    check("clean_mem5", mem[5], 32'h1005);
    check("clean_mem63", mem[63], 32'h103F);

    // Read data bit 0 flipped at word 5.
    do_reset();
    flip_word = 5;
    run_pass(32'h0, 32'h1000, 1'b0, dones, tmo, bsy);
    flip_word = -1;
    check("flip_timeout", tmo, 0);
    check("flip_err", err_count, 1);
    check("flip_first", first_err, 32'h14);
    check("flip_pass", pass, 0);

    // SLVERR on the write response of burst 2.
    do_reset();
    bresp_err_burst = 2;
    run_pass(32'h2000_0000, 32'h1000, 1'b0, dones, tmo, bsy);
    bresp_err_burst = -1;
    check("bresp_timeout", tmo, 0);
    check("bresp_err", err_count, 1);
    check("bresp_first", first_err, 32'h2000_0020);
    check("bresp_pass", pass, 0);
    check("bresp_proto", proto_err, 0);

    // Random 50% stalls on every slave-side handshake.
    do_reset();
    stall_en = 1'b1;
    run_pass(32'h0, 32'h1000, 1'b0, dones, tmo, bsy);
    stall_en = 1'b0;
    check("stall_timeout", tmo, 0);
    check("stall_done_pulses", dones, 1);
    check("stall_pass", pass, 1);
    check("stall_err", err_count, 0);
    check("stall_stable", stab_err, 0);
    check("stall_w", w_cnt, 64);
    check("stall_r", r_cnt, 64);
    check("stall_proto", proto_err, 0);

    // RLAST on beat 2 instead of beat 3 in burst 0.
    do_reset();
    early_rlast = 1'b1;
    run_pass(32'h0, 32'h1000, 1'b0, dones, tmo, bsy);
    early_rlast = 1'b0;
    check("rlast_timeout", tmo, 0);
    check("rlast_err", err_count, 2);
    check("rlast_first", first_err, 32'h8);
    check("rlast_pass", pass, 0);

    // Reset while write data is in flight, then a fresh pass.
    do_reset();
    cur_base  = 32'h0;
    base_addr = 32'h0;
    seed      = 32'h1000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_w = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.wvalid) begin
        saw_w = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_w", saw_w, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
    check("abort_busy", busy, 0);
    rst   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_pass(32'h0, 32'h1000, 1'b0, dones, tmo, bsy);
    check("abort_rerun_timeout", tmo, 0);
    check("abort_rerun_pass", pass, 1);
    check("abort_rerun_err", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
